// File: rtl/alu_mdu_pkg.sv
// Shared types for the EX-stage ALU / multiply-divide unit.
package alu_mdu_pkg;

    localparam int unsigned XlenDefault = 32;

    typedef enum logic [4:0] {
        AluAdd    = 5'd0,
        AluSub    = 5'd1,
        AluXor    = 5'd2,
        AluOr     = 5'd3,
        AluAnd    = 5'd4,
        AluSll    = 5'd5,
        AluSrl    = 5'd6,
        AluSra    = 5'd7,
        AluSlt    = 5'd8,
        AluSltu   = 5'd9,
        AluMul    = 5'd10,
        AluMulh   = 5'd11,
        AluMulhsu = 5'd12,
        AluMulhu  = 5'd13,
        AluDiv    = 5'd14,
        AluDivu   = 5'd15,
        AluRem    = 5'd16,
        AluRemu   = 5'd17
    } AluOp_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_op(input AluOp_e op);
        return (op >= AluMul) && (op <= AluRemu);
    endfunction

    function automatic logic is_div_op(input AluOp_e op);
        return (op >= AluDiv) && (op <= AluRemu);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative radix-2 multiply / restoring-divide datapath operating on magnitudes.
// o_hi/o_lo expose the result of the current step so the last step can be consumed directly.
module alu_mdu_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_mag_a,
    input  logic [XLEN-1:0] i_mag_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    import alu_mdu_pkg::*;

    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic            div_q, div_d, run_q, run_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN:0]   sum, tmp, diff;
    logic [XLEN-1:0] hi_step, lo_step;

    // hi holds the partial product / running remainder; lo the multiplier / quotient bits.
    always_comb begin
        sum  = {1'b0, hi_q} + {1'b0, b_q};
        tmp  = {hi_q, lo_q[XLEN-1]};
        diff = tmp - {1'b0, b_q};
        if (div_q) begin
            if (!diff[XLEN]) begin
                hi_step = diff[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_step = tmp[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            hi_step = sum[XLEN:1];
            lo_step = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_step = {1'b0, hi_q[XLEN-1:1]};
            lo_step = {hi_q[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;
        run_d = run_q;
        cnt_d = cnt_q;
        if (i_abort) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (i_start) begin
            hi_d  = '0;
            lo_d  = i_mag_a;
            b_d   = i_mag_b;
            div_d = i_is_div;
            run_d = 1'b1;
            cnt_d = CW'(XLEN);
        end else if (run_q) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_last = run_q && (cnt_q == CW'(1));
    assign o_hi   = hi_step;
    assign o_lo   = lo_step;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle RV32I ALU ops plus iterative RV32M multiply/divide,
// with request/result valid-ready handshakes and flush.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  AluOp_e          i_alu_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_alu_res
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    AluOp_e          op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            accept, iter_start, iter_last;
    logic [XLEN-1:0] iter_hi, iter_lo;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res, spec_res, mdu_res;
    logic            a_signed, b_signed, a_neg, b_neg, special;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [2*XLEN-1:0] prod_full, prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;

    assign accept = i_valid && (state_q == StIdle) && !i_flush;
    assign shamt  = i_operand_b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (i_alu_op)
            AluAdd:  base_res = i_operand_a + i_operand_b;
            AluSub:  base_res = i_operand_a - i_operand_b;
            AluXor:  base_res = i_operand_a ^ i_operand_b;
            AluOr:   base_res = i_operand_a | i_operand_b;
            AluAnd:  base_res = i_operand_a & i_operand_b;
            AluSll:  base_res = i_operand_a << shamt;
            AluSrl:  base_res = i_operand_a >> shamt;
            AluSra:  base_res = $signed(i_operand_a) >>> shamt;
            AluSlt:  base_res = {{(XLEN-1){1'b0}}, $signed(i_operand_a) < $signed(i_operand_b)};
            AluSltu: base_res = {{(XLEN-1){1'b0}}, i_operand_a < i_operand_b};
            default: base_res = '0;
        endcase
    end

    // Operand signedness, magnitudes, and divide corner cases that bypass the iterator.
    always_comb begin
        a_signed = (i_alu_op == AluMul) || (i_alu_op == AluMulh) || (i_alu_op == AluMulhsu)
                || (i_alu_op == AluDiv) || (i_alu_op == AluRem);
        b_signed = (i_alu_op == AluMul) || (i_alu_op == AluMulh)
                || (i_alu_op == AluDiv) || (i_alu_op == AluRem);
        a_neg    = a_signed && i_operand_a[XLEN-1];
        b_neg    = b_signed && i_operand_b[XLEN-1];
        mag_a    = a_neg ? -i_operand_a : i_operand_a;
        mag_b    = b_neg ? -i_operand_b : i_operand_b;
        special  = 1'b0;
        spec_res = '0;
        if (is_div_op(i_alu_op) && (i_operand_b == '0)) begin
            special  = 1'b1;
            spec_res = ((i_alu_op == AluDiv) || (i_alu_op == AluDivu)) ? '1 : i_operand_a;
        end else if (((i_alu_op == AluDiv) || (i_alu_op == AluRem))
                     && (i_operand_a == MinInt) && (i_operand_b == '1)) begin
            special  = 1'b1;
            spec_res = (i_alu_op == AluDiv) ? MinInt : '0;
        end
    end

    // Sign correction applied to the final iterator step.
    always_comb begin
        prod_full = {iter_hi, iter_lo};
        prod_fix  = neg_q ? -prod_full : prod_full;
        quot_fix  = neg_q ? -iter_lo : iter_lo;
        rem_fix   = neg_q ? -iter_hi : iter_hi;
        case (op_q)
            AluMul:                      mdu_res = prod_fix[XLEN-1:0];
            AluMulh, AluMulhsu, AluMulhu: mdu_res = prod_fix[2*XLEN-1:XLEN];
            AluDiv, AluDivu:             mdu_res = quot_fix;
            AluRem, AluRemu:             mdu_res = rem_fix;
            default:                     mdu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_d      = neg_q;
        res_d      = res_q;
        iter_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mdu_op(i_alu_op) && !special) begin
                        iter_start = 1'b1;
                        op_d       = i_alu_op;
                        neg_d      = (i_alu_op == AluRem) ? a_neg : (a_neg ^ b_neg);
                        state_d    = StBusy;
                    end else begin
                        res_d   = special ? spec_res : base_res;
                        state_d = StDone;
                    end
                end
            end
            StBusy: begin
                if (iter_last) begin
                    res_d   = mdu_res;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_flush) begin
            state_d    = StIdle;
            res_d      = res_q;
            iter_start = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            op_q    <= AluAdd;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    alu_mdu_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (iter_start),
        .i_abort (i_flush),
        .i_is_div(is_div_op(i_alu_op)),
        .i_mag_a (mag_a),
        .i_mag_b (mag_b),
        .o_last  (iter_last),
        .o_hi    (iter_hi),
        .o_lo    (iter_lo)
    );

    assign o_ready   = (state_q == StIdle);
    assign o_valid   = (state_q == StDone);
    assign o_alu_res = res_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk, rst_n, flush, valid_in, ready_out, valid_out, ready_in;
    AluOp_e      op;
    logic [31:0] opa, opb, res;

    int total = 0;
    int bad   = 0;

    alu_mdu #(.XLEN(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_valid    (valid_in),
        .o_ready    (ready_out),
        .i_alu_op   (op),
        .i_operand_a(opa),
        .i_operand_b(opb),
        .o_valid    (valid_out),
        .i_ready    (ready_in),
        .o_alu_res  (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input AluOp_e o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            AluAdd:    return a + b;
            AluSub:    return a - b;
            AluXor:    return a ^ b;
            AluOr:     return a | b;
            AluAnd:    return a & b;
            AluSll:    return a << b[4:0];
            AluSrl:    return a >> b[4:0];
            AluSra:    begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
            AluSlt:    return (sa < sb) ? 32'd1 : 32'd0;
            AluSltu:   return (ua < ub) ? 32'd1 : 32'd0;
            AluMul:    begin p = 64'(sa * sb); return p[31:0]; end
            AluMulh:   begin p = 64'(sa * sb); return p[63:32]; end
            AluMulhsu: begin p = 64'(sa * ub); return p[63:32]; end
            AluMulhu:  begin p = 64'(ua * ub); return p[63:32]; end
            AluDiv: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb);
                return p[31:0];
            end
            AluDivu: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            AluRem: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            AluRemu: begin
                if (b == 0) return a;
                return a % b;
            end
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input AluOp_e o, input logic [31:0] a, input logic [31:0] b);
        if (o inside {AluMul, AluMulh, AluMulhsu, AluMulhu}) return 33;
        if (o inside {AluDiv, AluDivu, AluRem, AluRemu}) begin
            if (b == 0) return 1;
            if ((o == AluDiv || o == AluRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
        return 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        opa = $urandom;
        opb = $urandom;
        op  = AluOp_e'(5'($urandom_range(0, 17)));
    endtask

    task automatic run_op(input AluOp_e o, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] exp_res;
        int exp_lat, lat;
        exp_res = ref_res(o, a, b);
        exp_lat = ref_lat(o, a, b);
        @(negedge clk);
        check_eq("ready_idle", 32'(ready_out), 32'd1);
        op = o; opa = a; opb = b; valid_in = 1'b1; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        scramble();
        lat = 1;
        while (!valid_out && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq($sformatf("lat op%0d", o), 32'(lat), 32'(exp_lat));
        check_eq($sformatf("res op%0d a=%08h b=%08h", o, a, b), res, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(valid_out), 32'd1);
            check_eq("hold_ready", 32'(ready_out), 32'd0);
            check_eq("hold_res", res, exp_res);
        end
        @(negedge clk);
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        check_eq("release_valid", 32'(valid_out), 32'd0);
        check_eq("release_ready", 32'(ready_out), 32'd1);
        ready_in = 1'b0;
    endtask

    task automatic watch_no_valid(input string tag);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    task automatic start_and_wait(input AluOp_e o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; opa = a; opb = b; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        op = AluAdd; opa = '0; opb = '0;
        #1;
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_res", res, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", 32'(ready_out), 32'd1);

        run_op(AluAdd, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(AluSra, 32'h8000_0000, 32'h24, 0);
        run_op(AluMul, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(AluMulh, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(AluMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(AluMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(AluDiv, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(AluRem, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(AluDivu, 32'd100, 32'd7, 0);
        run_op(AluRemu, 32'd100, 32'd7, 0);
        run_op(AluDivu, 32'd5, 32'd0, 0);
        run_op(AluRem, 32'd5, 32'd0, 0);
        run_op(AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(AluRem, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(AluSlt, 32'hFFFF_FFFF, 32'd1, 5);
        run_op(AluOp_e'(5'd22), 32'd9, 32'd3, 0);

        // Flush mid-divide; the ADD offered alongside the flush must be ignored.
        start_and_wait(AluDivu, 32'd1000, 32'd7);
        @(negedge clk);
        flush = 1'b1; valid_in = 1'b1; op = AluAdd; opa = 32'd4; opb = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        check_eq("flush_ready", 32'(ready_out), 32'd1);
        check_eq("flush_valid", 32'(valid_out), 32'd0);
        watch_no_valid("flush_no_valid");
        run_op(AluAdd, 32'd1, 32'd2, 0);

        // Asynchronous reset mid-multiply.
        start_and_wait(AluMul, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(valid_out), 32'd0);
        check_eq("midrst_res", res, 32'd0);
        check_eq("midrst_ready", 32'(ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("rst_no_valid");
        run_op(AluSub, 32'd1, 32'd2, 0);

        for (int n = 0; n < 60; n++) begin
            run_op(AluOp_e'(5'($urandom_range(0, 19))), pick(), pick(), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
